// File: rtl/csr_pkg.sv
// Shared definitions for the DMA CSR bus: widths, master states and the
// register offsets decoded by the DMA CSR slave.
package csr_pkg;

    localparam int CSR_ADDR_W = 32;
    localparam int CSR_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } csr_master_state_t;

    // Register map of the DMA CSR slave (byte offsets, word aligned)
    localparam logic [CSR_ADDR_W-1:0] CSR_DMA_CTRL   = 32'h0000_0000;
    localparam logic [CSR_ADDR_W-1:0] CSR_DMA_SRC    = 32'h0000_0004;
    localparam logic [CSR_ADDR_W-1:0] CSR_DMA_DST    = 32'h0000_0008;
    localparam logic [CSR_ADDR_W-1:0] CSR_DMA_LEN    = 32'h0000_000C;
    localparam logic [CSR_ADDR_W-1:0] CSR_DMA_CFG    = 32'h0000_0010;

endpackage

// File: rtl/csr_timeout_cnt.sv
// Wait-request timer. Down-counter loaded with TIMEOUT-1 on clear and
// decremented on every stalled cycle; expired flags terminal count, which
// corresponds to TIMEOUT-1 stalled cycles having elapsed since clear.
module csr_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Reload on clear, count down while stalled, saturate at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= LOAD;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/csr_master.sv
// CSR bus initiator: accepts one host command at a time, runs a single
// write or read on the CSR bus honouring wait-request with a timeout, and
// returns the result on a valid/ready response port.
//
//   state | meaning
//   IDLE  | ready for a command (cmd_ready=1 once out of reset)
//   WRITE | csr_wr asserted, waiting for csr_wait_rq=0 or timeout
//   READ  | csr_rd asserted, waiting for csr_wait_rq=0 or timeout
//   RESP  | response held on rsp_* until rsp_ready
module csr_master
    import csr_pkg::*;
#(
    parameter int                ADDR_W   = CSR_ADDR_W,
    parameter int                DATA_W   = CSR_DATA_W,
    parameter int                TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              csr_wr,
    output logic              csr_rd,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [DATA_W-1:0] csr_wr_data,
    input  logic              csr_wait_rq,
    input  logic [DATA_W-1:0] csr_rd_data
);

    csr_master_state_t state;
    logic              busy;
    logic              tmo_clear;
    logic              tmo_expired;

    assign busy      = (state == WRITE) || (state == READ);
    assign tmo_clear = (state == IDLE);

    csr_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (busy && csr_wait_rq),
        .expired (tmo_expired)
    );

    // Transaction sequencer; every output is a register so strobes are glitch-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            csr_wr      <= 1'b0;
            csr_rd      <= 1'b0;
            csr_addr    <= '0;
            csr_wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        rsp_write <= cmd_write;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        if (cmd_addr[1:0] != 2'b00) begin
                            // Misaligned: answer immediately, no bus cycle
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            if (!cmd_write) begin
                                rsp_rdata <= ERR_DATA;
                            end
                            state <= RESP;
                        end else begin
                            csr_addr    <= cmd_addr;
                            csr_wr_data <= cmd_wdata;
                            csr_wr      <= cmd_write;
                            csr_rd      <= !cmd_write;
                            state       <= cmd_write ? WRITE : READ;
                        end
                    end else begin
                        // Also brings cmd_ready up one cycle after reset release
                        cmd_ready <= 1'b1;
                    end
                end

                WRITE, READ: begin
                    if (!csr_wait_rq) begin
                        // Completion wins over a simultaneous terminal count
                        csr_wr    <= 1'b0;
                        csr_rd    <= 1'b0;
                        if (state == READ) begin
                            rsp_rdata <= csr_rd_data;
                        end
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (tmo_expired) begin
                        csr_wr    <= 1'b0;
                        csr_rd    <= 1'b0;
                        rsp_err   <= 1'b1;
                        if (state == READ) begin
                            rsp_rdata <= ERR_DATA;
                        end
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_master.sv
// Directed bench for csr_master with hand-computed expectations.
module tb_csr_master;
    import csr_pkg::*;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        csr_wr;
    logic        csr_rd;
    logic [31:0] csr_addr;
    logic [31:0] csr_wr_data;
    logic        csr_wait_rq;
    logic [31:0] csr_rd_data;

    int n_checks = 0;
    int n_errors = 0;

    csr_master #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (16),
        .ERR_DATA (32'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .csr_wr      (csr_wr),
        .csr_rd      (csr_rd),
        .csr_addr    (csr_addr),
        .csr_wr_data (csr_wr_data),
        .csr_wait_rq (csr_wait_rq),
        .csr_rd_data (csr_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
    endtask

    // Strobes must never overlap
    always @(negedge clk) begin
        if (!reset && csr_wr && csr_rd) begin
            chk("strobe_excl", {csr_wr, csr_rd}, 2'b10);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        rsp_ready   = 1'b0;
        csr_wait_rq = 1'b0;
        csr_rd_data = '0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_outputs", {rsp_valid, csr_wr, csr_rd, rsp_err}, 0);
        step();
        reset = 1'b0;
        step();
        chk("idle_cmd_ready", cmd_ready, 1);

        // Zero-wait write
        issue(1'b1, CSR_DMA_CFG, 32'hA5A5_5A5A);
        chk("wr_t1_csr_wr", {csr_wr, csr_rd}, 2'b10);
        chk("wr_t1_addr", csr_addr, 32'h0000_0010);
        chk("wr_t1_data", csr_wr_data, 32'hA5A5_5A5A);
        chk("wr_t1_rdy", {cmd_ready, rsp_valid}, 2'b00);
        step();
        chk("wr_t2_strobe", csr_wr, 0);
        chk("wr_t2_rsp", {rsp_valid, rsp_err, rsp_write}, 3'b101);
        chk("wr_t2_rdata", rsp_rdata, 0);
        release_rsp();

        // Read with two wait cycles
        csr_wait_rq = 1'b1;
        issue(1'b0, CSR_DMA_SRC, 32'h0);
        chk("rd_t1", {csr_rd, csr_wr}, 2'b10);
        chk("rd_t1_addr", csr_addr, 32'h0000_0004);
        step();
        chk("rd_t2", csr_rd, 1);
        step();
        chk("rd_t3", csr_rd, 1);
        csr_wait_rq = 1'b0;
        csr_rd_data = 32'h1234_5678;
        step();
        csr_rd_data = 32'hFFFF_FFFF;
        chk("rd_t4_strobe", csr_rd, 0);
        chk("rd_t4_rsp", {rsp_valid, rsp_err, rsp_write}, 3'b100);
        chk("rd_t4_rdata", rsp_rdata, 32'h1234_5678);
        release_rsp();

        // Read with wait-request stuck high
        csr_wait_rq = 1'b1;
        issue(1'b0, CSR_DMA_DST, 32'h0);
        n = 0;
        while (csr_rd && n < 40) begin
            n++;
            step();
        end
        chk("tmo_rd_cycles", n, 16);
        chk("tmo_rsp", {rsp_valid, rsp_err, rsp_write}, 3'b110);
        chk("tmo_rdata", rsp_rdata, 0);
        csr_wait_rq = 1'b0;
        release_rsp();

        // Completion on the terminal-count cycle is not an error
        csr_wait_rq = 1'b1;
        issue(1'b0, CSR_DMA_LEN, 32'h0);
        for (int i = 0; i < 15; i++) begin
            step();
        end
        chk("edge_t16_rd", csr_rd, 1);
        csr_wait_rq = 1'b0;
        csr_rd_data = 32'hCAFE_F00D;
        step();
        chk("edge_rsp", {csr_rd, rsp_valid, rsp_err}, 3'b010);
        chk("edge_rdata", rsp_rdata, 32'hCAFE_F00D);
        release_rsp();

        // Misaligned write, then response stalled for 5 cycles
        issue(1'b1, 32'h0000_0006, 32'h1111_2222);
        chk("mis_no_strobe", {csr_wr, csr_rd}, 0);
        chk("mis_rsp", {rsp_valid, rsp_err, rsp_write}, 3'b111);
        chk("mis_rdata", rsp_rdata, 0);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = CSR_DMA_CTRL;
        cmd_wdata = 32'h0000_0001;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_rsp", {rsp_valid, rsp_err, rsp_write, cmd_ready, csr_wr}, 5'b11100);
            chk("stall_rdata", rsp_rdata, 0);
        end
        cmd_valid = 1'b0;
        release_rsp();
        chk("stall_no_accept", csr_wr, 0);

        // Reset in the middle of a stalled read
        csr_wait_rq = 1'b1;
        issue(1'b0, CSR_DMA_SRC, 32'h0);
        step();
        chk("mid_rd_active", csr_rd, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_strobe", {csr_rd, rsp_valid, cmd_ready}, 0);
        csr_wait_rq = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("post_rst", {cmd_ready, rsp_valid, csr_rd}, 3'b100);
        issue(1'b1, CSR_DMA_LEN, 32'hDEAD_BEEF);
        chk("post_wr_t1", {csr_wr, csr_addr, csr_wr_data}, {1'b1, 32'h0000_000C, 32'hDEAD_BEEF});
        step();
        chk("post_wr_t2", {rsp_valid, rsp_err, rsp_write}, 3'b101);
        release_rsp();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
